// File: rtl/spr_line_rend.sv
// spr_line_rend - per-scanline sprite renderer.
//
// Holds up to NUM_SPR sprite slots. During hblank (LOAD) sprite words are
// accepted in order through load_valid/load_ready; during the visible line
// (DRAW) each pix_valid cycle produces one registered palette index, chosen
// as the lowest-index slot with an opaque pixel at pixel_x.
//
// Optional feature macro: SPR_ZERO_HIT_EN (sticky sprite-0 hit detection).
// Without it spr0_hit is tied low and bg_opaque is unused.
//
// Ports:
//   clk            pixel clock (posedge)
//   reset          asynchronous, active-high
//   line_start     pulse; clears slots, spr_count and overflow, enters LOAD
//   load_valid     load_data holds a sprite word
//   load_ready     LOAD state with a free slot
//   load_data      {ign, hflip, prio, ign[2:0], palette[1:0], xpos, plane1, plane0}
//   draw_en        level; moves LOAD -> DRAW
//   pix_valid      pixel_x valid this cycle
//   pixel_x        current screen X
//   bg_opaque      background pixel opaque (sprite-0 hit only)
//   pallete_colour {palette, pattern} of winning slot (1-cycle latency)
//   valid          pallete_colour is an opaque sprite pixel
//   behind_bg      priority bit of winning slot
//   spr_count      slots loaded this line
//   overflow       sticky: load attempted with all slots full
//   spr0_hit       sticky sprite-0 hit (cleared only by reset)
module spr_line_rend #(
    parameter int NUM_SPR = 8,
    parameter int XW      = 8,
    parameter int CNT_W   = $clog2(NUM_SPR + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_data,
    input  logic             draw_en,
    input  logic             pix_valid,
    input  logic [XW-1:0]    pixel_x,
    input  logic             bg_opaque,
    output logic [3:0]       pallete_colour,
    output logic             valid,
    output logic             behind_bg,
    output logic [CNT_W-1:0] spr_count,
    output logic             overflow,
    output logic             spr0_hit
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SPR);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             vld_q, vld_d;
    logic [3:0]       col_q, col_d;
    logic             pri_q, pri_d;
    logic             hit_q, hit_d;
    logic             accept;
    logic [31:0]      xpos_ext;

    // Slot storage: data only, validity is implied by slot index < cnt_q.
    logic [7:0]    p0_q   [NUM_SPR];
    logic [7:0]    p1_q   [NUM_SPR];
    logic [XW-1:0] xpos_q [NUM_SPR];
    logic [1:0]    pal_q  [NUM_SPR];
    logic          prio_q [NUM_SPR];
    logic          flip_q [NUM_SPR];

    // Pattern of one slot at pixel px; 00 when the slot does not cover px.
    // The XW+1-bit difference carries a borrow in its MSB when px < xpos,
    // so no wrap-around coverage is possible.
    function automatic logic [1:0] slot_pat(input logic [XW-1:0] px,
                                            input logic [XW-1:0] xp,
                                            input logic [7:0]    p0,
                                            input logic [7:0]    p1,
                                            input logic          flip);
        logic [XW:0] diff;
        logic [2:0]  idx;
        diff = {1'b0, px} - {1'b0, xp};
        idx  = flip ? diff[2:0] : (3'd7 - diff[2:0]);
        if (diff[XW:3] != '0) return 2'b00;
        return {p1[idx], p0[idx]};
    endfunction

    assign load_ready = (state_q == S_LOAD) && (cnt_q < FULL);
    assign accept     = load_valid && load_ready && !line_start;
    assign xpos_ext   = {24'd0, load_data[23:16]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_LOAD:  if (draw_en) state_d = S_DRAW;
            S_DRAW:  state_d = S_DRAW;
            default: state_d = S_IDLE;
        endcase
        if (accept) cnt_d = cnt_q + CNT_W'(1);
        if (load_valid && (state_q == S_LOAD) && (cnt_q == FULL)) ovf_d = 1'b1;
        // line_start overrides everything, including a same-cycle load.
        if (line_start) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // Render: walk from the highest slot down so the lowest-index opaque
    // slot is the last to write the winner.
    always_comb begin
        logic [1:0] pat;
        logic       found;
        found = 1'b0;
        col_d = 4'd0;
        pri_d = 1'b0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            pat = slot_pat(pixel_x, xpos_q[i], p0_q[i], p1_q[i], flip_q[i]);
            if ((CNT_W'(i) < cnt_q) && (pat != 2'b00)) begin
                found = 1'b1;
                col_d = {pal_q[i], pat};
                pri_d = prio_q[i];
            end
        end
        vld_d = (state_q == S_DRAW) && pix_valid && found;
        if (!vld_d) begin
            col_d = 4'd0;
            pri_d = 1'b0;
        end
    end

`ifdef SPR_ZERO_HIT_EN
    logic s0_cand;
    assign s0_cand = (cnt_q != '0) &&
                     (slot_pat(pixel_x, xpos_q[0], p0_q[0], p1_q[0], flip_q[0]) != 2'b00);
    assign hit_d   = hit_q | ((state_q == S_DRAW) && pix_valid && s0_cand &&
                              bg_opaque && (pixel_x != '1));
    logic unused_sig;
    assign unused_sig = ^{load_data[31], load_data[28:26], xpos_ext};
`else
    assign hit_d = 1'b0;
    logic unused_sig;
    assign unused_sig = ^{load_data[31], load_data[28:26], xpos_ext, bg_opaque};
`endif

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            col_q   <= 4'd0;
            pri_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            col_q   <= col_d;
            pri_q   <= pri_d;
            hit_q   <= hit_d;
        end
    end

    // Slot data registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SPR; i++) begin
            if (accept && (cnt_q == CNT_W'(i))) begin
                p0_q[i]   <= load_data[7:0];
                p1_q[i]   <= load_data[15:8];
                xpos_q[i] <= xpos_ext[XW-1:0];
                pal_q[i]  <= load_data[25:24];
                prio_q[i] <= load_data[29];
                flip_q[i] <= load_data[30];
            end
        end
    end

    assign pallete_colour = col_q;
    assign valid          = vld_q;
    assign behind_bg      = pri_q;
    assign spr_count      = cnt_q;
    assign overflow       = ovf_q;
    assign spr0_hit       = hit_q;

endmodule

// File: tb/tb_spr_line_rend.sv
module tb_spr_line_rend;
    localparam int NUM_SPR = 8;
    localparam int XW      = 8;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset, line_start, load_valid, draw_en, pix_valid, bg_opaque;
    logic [31:0]      load_data;
    logic [XW-1:0]    pixel_x;
    logic             load_ready, valid, behind_bg, overflow, spr0_hit;
    logic [3:0]       pallete_colour;
    logic [CNT_W-1:0] spr_count;

    spr_line_rend #(.NUM_SPR(NUM_SPR), .XW(XW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .line_start(line_start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .draw_en(draw_en), .pix_valid(pix_valid), .pixel_x(pixel_x),
        .bg_opaque(bg_opaque), .pallete_colour(pallete_colour), .valid(valid),
        .behind_bg(behind_bg), .spr_count(spr_count), .overflow(overflow),
        .spr0_hit(spr0_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] col;
        logic       pri;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [31:0] m_words[$];

`ifdef SPR_ZERO_HIT_EN
    localparam logic HIT_EXP = 1'b1;
`else
    localparam logic HIT_EXP = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int xp, input logic [7:0] p0, input logic [7:0] p1,
                                       input logic [1:0] pal, input logic pri, input logic hf);
        logic [7:0] x8;
        x8 = 8'(xp);
        return {1'b0, hf, pri, 3'b000, pal, x8, p1, p0};
    endfunction

    // Reference: first slot in load order whose pixel is non-transparent.
    function automatic exp_t model_pix(input int x);
        exp_t        e;
        logic [31:0] w;
        logic [7:0]  p0, p1;
        int          xp, off;
        logic [1:0]  pat;
        e = '0;
        for (int i = 0; i < m_words.size(); i++) begin
            w  = m_words[i];
            xp = int'(w[23:16]);
            p0 = w[7:0];
            p1 = w[15:8];
            if (w[30]) begin
                p0 = {<<{w[7:0]}};
                p1 = {<<{w[15:8]}};
            end
            if (x >= xp && x - xp < 8) begin
                off = x - xp;
                pat = {p1[7 - off], p0[7 - off]};
                if (pat != 2'b00) begin
                    e.v   = 1'b1;
                    e.col = {w[25:24], pat};
                    e.pri = w[29];
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_line_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        m_words.delete();
    endtask

    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
        if (m_words.size() < NUM_SPR) m_words.push_back(w);
    endtask

    task automatic start_draw();
        draw_en = 1'b1;
        tick();
        draw_en = 1'b0;
    endtask

    task automatic render(input int x, input logic pv, input logic in_draw);
        exp_t e;
        pixel_x   = XW'(x);
        pix_valid = pv;
        sb_q.push_back((pv && in_draw) ? model_pix(x) : exp_t'('0));
        tick();
        pix_valid = 1'b0;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("valid@x%0d", x), valid, e.v);
            check($sformatf("colour@x%0d", x), pallete_colour, e.col);
            check($sformatf("behind@x%0d", x), behind_bg, e.pri);
        end
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int x = lo; x <= hi; x++) render(x, 1'b1, 1'b1);
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; load_valid = 1'b0; draw_en = 1'b0;
        pix_valid = 1'b0; bg_opaque = 1'b0; load_data = '0; pixel_x = '0;
        tick(); tick();
        check("rst_load_ready", load_ready, 0);
        check("rst_valid", valid, 0);
        check("rst_colour", pallete_colour, 0);
        check("rst_behind", behind_bg, 0);
        check("rst_count", spr_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_hit", spr0_hit, 0);
        reset = 1'b0;
        tick();

        // Loads in IDLE are ignored
        load_valid = 1'b1; load_data = mk(1, 8'hFF, 8'hFF, 0, 0, 0);
        tick();
        load_valid = 1'b0;
        check("idle_count", spr_count, 0);
        check("idle_overflow", overflow, 0);

        // Basic load and render
        do_line_start();
        check("load_ready", load_ready, 1);
        load_word(mk(10, 8'h80, 8'h00, 2, 0, 0));
        check("count_1", spr_count, 1);
        render(10, 1'b1, 1'b0);
        start_draw();
        check("draw_ready", load_ready, 0);
        sweep(0, 20);
        render(10, 1'b0, 1'b1);
        render(10, 1'b1, 1'b1);
        check("direct_colour_x10", pallete_colour, 4'h9);

        // Horizontal flip, with junk in ignored bits
        do_line_start();
        load_word(mk(10, 8'h80, 8'h00, 2, 0, 1) | 32'h9C00_0000);
        start_draw();
        sweep(0, 20);

        // Arbitration and transparency
        do_line_start();
        load_word(mk(5, 8'h0F, 8'h00, 0, 0, 0));
        load_word(mk(5, 8'hFF, 8'hFF, 3, 1, 0));
        check("count_2", spr_count, 2);
        start_draw();
        sweep(3, 14);

        // Overflow
        do_line_start();
        load_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            load_data = mk(i * 9, 8'(i + 1), 8'h00, 2'(i), 0, 0);
            tick();
            if (m_words.size() < NUM_SPR) m_words.push_back(load_data);
        end
        load_valid = 1'b0;
        check("ovf_count", spr_count, 8);
        check("ovf_ready", load_ready, 0);
        check("ovf_flag", overflow, 1);
        start_draw();
        sweep(0, 12);
        do_line_start();
        check("ls_count", spr_count, 0);
        check("ls_overflow", overflow, 0);
        check("ls_ready", load_ready, 1);

        // Right edge, no wrap
        do_line_start();
        load_word(mk(252, 8'hFF, 8'hFF, 1, 0, 0));
        start_draw();
        sweep(248, 255);
        sweep(0, 3);
        load_valid = 1'b1; load_data = mk(0, 8'hFF, 8'hFF, 0, 0, 0);
        tick();
        load_valid = 1'b0;
        check("draw_load_count", spr_count, 1);
        check("draw_load_ovf", overflow, 0);

        // line_start and load_valid together
        do_line_start();
        line_start = 1'b1; load_valid = 1'b1; load_data = mk(7, 8'hFF, 8'h00, 0, 0, 0);
        tick();
        line_start = 1'b0; load_valid = 1'b0;
        check("simul_count", spr_count, 0);
        check("simul_ready", load_ready, 1);

        // Sprite-0 hit
        check("hit_before", spr0_hit, 0);
        do_line_start();
        load_word(mk(40, 8'h80, 8'h00, 1, 0, 0));
        start_draw();
        bg_opaque = 1'b1;
        sweep(38, 42);
        bg_opaque = 1'b0;
        check("hit_set", spr0_hit, HIT_EXP);
        do_line_start();
        tick();
        check("hit_sticky", spr0_hit, HIT_EXP);

        // Reset mid-DRAW
        do_line_start();
        load_word(mk(60, 8'hFF, 8'h00, 0, 0, 0));
        start_draw();
        render(60, 1'b1, 1'b1);
        pixel_x = 8'd61; pix_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_ready", load_ready, 0);
        check("mid_rst_count", spr_count, 0);
        check("mid_rst_hit", spr0_hit, 0);
        tick();
        check("mid_rst_valid_hold", valid, 0);
        reset = 1'b0;
        tick();
        check("idle_after_rst", valid, 0);
        pix_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
